// File: rtl/mii_uart_arbiter_pkg.sv
// Shared constants for the two-channel MII-to-UART frame arbiter.
package mii_uart_arbiter_pkg;

    // Default upper nibbles of the frame delimiter bytes.
    localparam logic [3:0] SOF_TAG_DEF = 4'hA;
    localparam logic [3:0] EOF_TAG_DEF = 4'hE;

    // FIFO entry is {marker, byte}.
    localparam int ENTRY_W = 9;

    // Scheduler state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SOF  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EOF  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_SOF  = ST_SOF,
        S_DATA = ST_DATA,
        S_EOF  = ST_EOF,
        S_GAP  = ST_GAP
    } sched_state_t;

endpackage

// File: rtl/mii_uart_arbiter_frame_fifo.sv
// Per-channel frame FIFO: stores data bytes and end-of-frame markers,
// counts complete frames and flags overflow. One slot is always held
// back for the marker so a full frame can always be terminated.
module mii_uart_arbiter_frame_fifo
    import mii_uart_arbiter_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [7:0]         data,
    input  logic               eof,
    input  logic               pop,
    input  logic               frame_done,
    output logic [ENTRY_W-1:0] head,
    output logic               frame_avail,
    output logic               ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LIM_DATA = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LIM_ALL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        frame_cnt;
    logic               eof_pend;
    logic               have_data;

    logic               data_ok;
    logic               mark_req;
    logic               mark_ok;
    logic               wr_en;
    logic               rd_en;
    logic [ENTRY_W-1:0] wr_entry;

    // Decide what (if anything) is written this cycle; data beats a marker.
    always_comb begin
        data_ok  = push && (count < LIM_DATA);
        mark_req = (eof_pend || eof) && !push;
        mark_ok  = mark_req && (count < LIM_ALL) && have_data;
        wr_en    = data_ok || mark_ok;
        rd_en    = pop && (count != '0);
        wr_entry = data_ok ? {1'b0, data} : {1'b1, 8'h00};
    end

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers, occupancy, frame count, marker bookkeeping and overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            eof_pend  <= 1'b0;
            have_data <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            case ({mark_ok, frame_done})
                2'b10:   frame_cnt <= frame_cnt + ONE;
                2'b01:   frame_cnt <= frame_cnt - ONE;
                default: frame_cnt <= frame_cnt;
            endcase
            // An eof coinciding with a byte is deferred one cycle.
            eof_pend <= push ? (eof_pend || eof) : 1'b0;
            if (data_ok)      have_data <= 1'b1;
            else if (mark_ok) have_data <= 1'b0;
            if (push && !data_ok) ovf <= 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign frame_avail = (frame_cnt != '0);

endmodule

// File: rtl/mii_uart_arbiter.sv
// Two-channel MII receive to single UART transmitter arbiter. Buffers
// whole frames per channel and sends them round-robin, each wrapped in
// {SOF_TAG,ch} ... {EOF_TAG,ch} delimiter bytes.
//
// state | meaning
// IDLE  | waiting for a complete buffered frame, picks channel
// SOF   | send start tag when UART is free
// DATA  | pop and send bytes until the marker entry is reached
// EOF   | send end tag, record served channel
// GAP   | one idle cycle before rescheduling
module mii_uart_arbiter
    import mii_uart_arbiter_pkg::*;
#(
    parameter int         DEPTH   = 128,
    parameter logic [3:0] SOF_TAG = SOF_TAG_DEF,
    parameter logic [3:0] EOF_TAG = EOF_TAG_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rdy0,
    input  logic [7:0] q0,
    input  logic       eof0,
    input  logic       rdy1,
    input  logic [7:0] q1,
    input  logic       eof1,
    input  logic       uart_active,
    output logic       uart_dv,
    output logic [7:0] uart_d,
    output logic [1:0] ovf,
    output logic       busy
);

    sched_state_t       state, state_nxt;
    logic               sel, sel_nxt;
    logic               rr_last, rr_nxt;
    logic [1:0]         rdy_q;
    logic [1:0]         push;
    logic [1:0]         pop;
    logic [1:0]         done;
    logic [1:0]         avail;
    logic [ENTRY_W-1:0] head0, head1, head_sel;
    logic               dv_q;
    logic               uart_free;
    logic               issue;
    logic [7:0]         issue_byte;

    assign push      = {rdy1, rdy0} & ~rdy_q;
    assign head_sel  = sel ? head1 : head0;
    // dv_q covers the cycle before uart_tx raises its active flag.
    assign uart_free = !uart_active && !uart_dv && !dv_q;
    assign busy      = (state == S_SOF) || (state == S_DATA) || (state == S_EOF);

    mii_uart_arbiter_frame_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push[0]),
        .data        (q0),
        .eof         (eof0),
        .pop         (pop[0]),
        .frame_done  (done[0]),
        .head        (head0),
        .frame_avail (avail[0]),
        .ovf         (ovf[0])
    );

    mii_uart_arbiter_frame_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push[1]),
        .data        (q1),
        .eof         (eof1),
        .pop         (pop[1]),
        .frame_done  (done[1]),
        .head        (head1),
        .frame_avail (avail[1]),
        .ovf         (ovf[1])
    );

    // Scheduler next-state, FIFO pop and UART issue decisions.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_nxt     = rr_last;
        issue      = 1'b0;
        issue_byte = 8'h00;
        pop        = 2'b00;
        done       = 2'b00;
        unique case (state)
            S_IDLE: begin
                if (|avail) begin
                    sel_nxt   = (&avail) ? ~rr_last : avail[1];
                    state_nxt = S_SOF;
                end
            end
            S_SOF: begin
                if (uart_free) begin
                    issue      = 1'b1;
                    issue_byte = {SOF_TAG, 3'b000, sel};
                    state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                if (uart_free) begin
                    pop = sel ? 2'b10 : 2'b01;
                    if (head_sel[8]) begin
                        done      = sel ? 2'b10 : 2'b01;
                        state_nxt = S_EOF;
                    end else begin
                        issue      = 1'b1;
                        issue_byte = head_sel[7:0];
                    end
                end
            end
            S_EOF: begin
                if (uart_free) begin
                    issue      = 1'b1;
                    issue_byte = {EOF_TAG, 3'b000, sel};
                    rr_nxt     = sel;
                    state_nxt  = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Scheduler registers, rdy edge history and UART handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            sel     <= 1'b0;
            rr_last <= 1'b1;
            rdy_q   <= 2'b00;
            uart_dv <= 1'b0;
            uart_d  <= 8'h00;
            dv_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            rr_last <= rr_nxt;
            rdy_q   <= {rdy1, rdy0};
            uart_dv <= issue;
            dv_q    <= uart_dv;
            if (issue) uart_d <= issue_byte;
        end
    end

endmodule

// File: tb/tb_mii_uart_arbiter.sv
// Directed bench for mii_uart_arbiter with a simple uart_tx model.
module tb_mii_uart_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rdy0 = 1'b0, rdy1 = 1'b0;
    logic [7:0] q0 = 8'h00, q1 = 8'h00;
    logic       eof0 = 1'b0, eof1 = 1'b0;
    logic       uart_active;
    logic       uart_dv;
    logic [7:0] uart_d;
    logic [1:0] ovf;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] cap[$];
    int bfm_cnt;
    int cyc = 0;
    int last_dv = -100;
    int spacing_err = 0;

    always #5 clk = ~clk;

    mii_uart_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rdy0        (rdy0),
        .q0          (q0),
        .eof0        (eof0),
        .rdy1        (rdy1),
        .q1          (q1),
        .eof1        (eof1),
        .uart_active (uart_active),
        .uart_dv     (uart_dv),
        .uart_d      (uart_d),
        .ovf         (ovf),
        .busy        (busy)
    );

    // uart_tx model: active rises the cycle after dv and stays up 6 cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bfm_cnt     <= 0;
            uart_active <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (uart_dv) begin
                cap.push_back(uart_d);
                if (cyc - last_dv < 3) spacing_err <= spacing_err + 1;
                last_dv     <= cyc;
                bfm_cnt     <= 6;
                uart_active <= 1'b1;
            end else if (bfm_cnt > 0) begin
                bfm_cnt     <= bfm_cnt - 1;
                uart_active <= (bfm_cnt > 1);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rdy0 = 0; rdy1 = 0; eof0 = 0; eof1 = 0;
        tick(); tick();
        cap.delete();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b);
        if (ch == 0) begin q0 = b; rdy0 = 1; end
        else         begin q1 = b; rdy1 = 1; end
        tick(); tick();
        rdy0 = 0; rdy1 = 0;
        tick(); tick();
    endtask

    task automatic pulse_eof(input logic [1:0] m);
        eof0 = m[0]; eof1 = m[1];
        tick();
        eof0 = 0; eof1 = 0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && cap.size() < n; i++) tick();
        ok = (cap.size() >= n);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_total++; if (uart_dv !== 1'b0) $display("FAIL rst_dv got %b want 0", uart_dv); else n_pass++;
        n_total++; if (uart_d !== 8'h00) $display("FAIL rst_d got %h want 00", uart_d); else n_pass++;
        n_total++; if (ovf !== 2'b00) $display("FAIL rst_ovf got %b want 00", ovf); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [7:0] exp[$];
        bit ok;
        do_reset();
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        eof0 = 1;
        tick();
        eof0 = 0;
        tick();
        n_total++; if (uart_dv !== 1'b0) $display("FAIL lat_early got dv=%b want 0", uart_dv); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL lat_busy got %b want 1", busy); else n_pass++;
        tick();
        n_total++; if (uart_dv !== 1'b1) $display("FAIL lat_sof got dv=%b want 1", uart_dv); else n_pass++;
        wait_bytes(5, 300, ok);
        repeat (10) tick();
        n_total++; if (!ok) $display("FAIL single_timeout got %0d bytes want 5", cap.size()); else n_pass++;
        exp = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'hE0};
        n_total++; if (cap.size() != exp.size()) $display("FAIL single_len got %0d want %0d", cap.size(), exp.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            n_total++;
            if (i >= cap.size()) $display("FAIL single_byte%0d got none want %h", i, exp[i]);
            else if (cap[i] !== exp[i]) $display("FAIL single_byte%0d got %h want %h", i, cap[i], exp[i]);
            else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else n_pass++;
        n_total++; if (ovf !== 2'b00) $display("FAIL single_ovf got %b want 00", ovf); else n_pass++;
        n_total++; if (spacing_err != 0) $display("FAIL dv_spacing got %0d violations want 0", spacing_err); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp[$];
        bit ok;
        do_reset();
        send_byte(1, 8'h5A);
        send_byte(0, 8'h01);
        send_byte(0, 8'h02);
        pulse_eof(2'b11);
        wait_bytes(7, 400, ok);
        repeat (10) tick();
        send_byte(0, 8'h44);
        pulse_eof(2'b01);
        wait_bytes(10, 400, ok);
        repeat (10) tick();
        send_byte(1, 8'h55);
        send_byte(0, 8'h66);
        pulse_eof(2'b11);
        wait_bytes(16, 400, ok);
        repeat (10) tick();
        n_total++; if (!ok) $display("FAIL rr_timeout got %0d bytes want 16", cap.size()); else n_pass++;
        exp = '{8'hA0, 8'h01, 8'h02, 8'hE0, 8'hA1, 8'h5A, 8'hE1,
                8'hA0, 8'h44, 8'hE0,
                8'hA1, 8'h55, 8'hE1, 8'hA0, 8'h66, 8'hE0};
        n_total++; if (cap.size() != exp.size()) $display("FAIL rr_len got %0d want %0d", cap.size(), exp.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            n_total++;
            if (i >= cap.size()) $display("FAIL rr_byte%0d got none want %h", i, exp[i]);
            else if (cap[i] !== exp[i]) $display("FAIL rr_byte%0d got %h want %h", i, cap[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int bad;
        do_reset();
        for (int i = 0; i < 130; i++) send_byte(0, 8'(i));
        n_total++; if (ovf !== 2'b01) $display("FAIL ovf_flag got %b want 01", ovf); else n_pass++;
        pulse_eof(2'b01);
        wait_bytes(129, 2500, ok);
        repeat (10) tick();
        n_total++; if (!ok) $display("FAIL ovf_timeout got %0d bytes want 129", cap.size()); else n_pass++;
        n_total++; if (cap.size() != 129) $display("FAIL ovf_len got %0d want 129", cap.size()); else n_pass++;
        n_total++;
        if (cap.size() < 1 || cap[0] !== 8'hA0) $display("FAIL ovf_sof got %h want a0", cap.size() ? cap[0] : 8'hxx);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 127; i++) begin
            if (i + 1 >= cap.size() || cap[i+1] !== 8'(i)) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL ovf_payload got %0d wrong bytes want 0", bad); else n_pass++;
        n_total++;
        if (cap.size() < 129 || cap[128] !== 8'hE0) $display("FAIL ovf_eof got %h want e0", cap.size() >= 129 ? cap[128] : 8'hxx);
        else n_pass++;
        n_total++; if (ovf !== 2'b01) $display("FAIL ovf_sticky got %b want 01", ovf); else n_pass++;
        n_total++; if (spacing_err != 0) $display("FAIL ovf_spacing got %0d violations want 0", spacing_err); else n_pass++;
    endtask

    task automatic test_empty_eof();
        logic [7:0] exp[$];
        bit ok;
        do_reset();
        pulse_eof(2'b11);
        repeat (30) tick();
        n_total++; if (cap.size() != 0) $display("FAIL empty_activity got %0d bytes want 0", cap.size()); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL empty_busy got %b want 0", busy); else n_pass++;
        send_byte(0, 8'h99);
        pulse_eof(2'b01);
        wait_bytes(3, 200, ok);
        repeat (40) tick();
        exp = '{8'hA0, 8'h99, 8'hE0};
        n_total++; if (cap.size() != exp.size()) $display("FAIL empty_follow_len got %0d want 3", cap.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            n_total++;
            if (i >= cap.size()) $display("FAIL empty_byte%0d got none want %h", i, exp[i]);
            else if (cap[i] !== exp[i]) $display("FAIL empty_byte%0d got %h want %h", i, cap[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle_eof();
        logic [7:0] exp[$];
        bit ok;
        do_reset();
        send_byte(0, 8'hC1);
        q0 = 8'hC2; rdy0 = 1; eof0 = 1;
        tick();
        eof0 = 0;
        tick();
        rdy0 = 0;
        tick(); tick();
        wait_bytes(4, 300, ok);
        repeat (10) tick();
        exp = '{8'hA0, 8'hC1, 8'hC2, 8'hE0};
        n_total++; if (cap.size() != exp.size()) $display("FAIL same_len got %0d want 4", cap.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            n_total++;
            if (i >= cap.size()) $display("FAIL same_byte%0d got none want %h", i, exp[i]);
            else if (cap[i] !== exp[i]) $display("FAIL same_byte%0d got %h want %h", i, cap[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp[$];
        bit ok;
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(0, 8'h80 + 8'(i));
        pulse_eof(2'b01);
        wait_bytes(4, 300, ok);
        tick(); tick();
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if (uart_dv !== 1'b0) $display("FAIL mid_rst_dv got %b want 0", uart_dv); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
        tick(); tick();
        cap.delete();
        reset_n = 1'b1;
        tick();
        send_byte(0, 8'h77);
        pulse_eof(2'b01);
        wait_bytes(3, 300, ok);
        repeat (60) tick();
        exp = '{8'hA0, 8'h77, 8'hE0};
        n_total++; if (cap.size() != exp.size()) $display("FAIL mid_len got %0d want 3", cap.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            n_total++;
            if (i >= cap.size()) $display("FAIL mid_byte%0d got none want %h", i, exp[i]);
            else if (cap[i] !== exp[i]) $display("FAIL mid_byte%0d got %h want %h", i, cap[i], exp[i]);
            else n_pass++;
        end
        n_total++; if (ovf !== 2'b00) $display("FAIL mid_ovf got %b want 00", ovf); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_overflow();
        test_empty_eof();
        test_same_cycle_eof();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
